// File: rtl/stream_pacer_fifo.sv
// Circular word buffer with registered occupancy; flush clears pointers and level.
module stream_pacer_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH):0]     level_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [LW-1:0]    r_level;

    // Storage is intentionally left unreset.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) begin
            r_mem[r_wptr] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else if (flush_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (push_i) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (pop_i) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign rdata_o = r_mem[r_rptr];
    assign level_o = r_level;
endmodule

// File: rtl/stream_pacer.sv
// Rate-limited stream buffer: pops at most once per RATE cycles into a registered strobe/data pair.
module stream_pacer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned RATE  = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   s_valid_i,
    output logic                   s_ready_o,
    input  logic [WIDTH-1:0]       s_data_i,
    output logic                   enable_o,
    output logic [WIDTH-1:0]       data_o,
    output logic [$clog2(DEPTH):0] level_o
);
    localparam int unsigned LW = $clog2(DEPTH) + 1;
    localparam int unsigned CW = $clog2(RATE) + 1;

    logic [LW-1:0]    w_level;
    logic [WIDTH-1:0] w_rdata;
    logic             w_ready;
    logic             w_push;
    logic             w_pop;
    logic [CW-1:0]    r_cnt;
    logic             r_enable;
    logic [WIDTH-1:0] r_data;

    // No bypass: a full buffer refuses a push even when it pops that cycle.
    assign w_ready = (w_level < LW'(DEPTH)) && !flush_i;
    assign w_push  = s_valid_i && w_ready;
    assign w_pop   = (r_cnt == '0) && (w_level != '0) && !flush_i;

    stream_pacer_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .push_i  (w_push),
        .wdata_i (s_data_i),
        .pop_i   (w_pop),
        .rdata_o (w_rdata),
        .level_o (w_level)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (flush_i) begin
            r_cnt <= '0;
        end else if (w_pop) begin
            r_cnt <= CW'(RATE - 1);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    // Data holds its last popped value, including across a flush.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_enable <= 1'b0;
            r_data   <= '0;
        end else if (flush_i) begin
            r_enable <= 1'b0;
        end else begin
            r_enable <= w_pop;
            if (w_pop) begin
                r_data <= w_rdata;
            end
        end
    end

    assign s_ready_o = w_ready;
    assign enable_o  = r_enable;
    assign data_o    = r_data;
    assign level_o   = w_level;
endmodule

// File: tb/tb_stream_pacer.sv
// Scoreboard bench for stream_pacer: one RATE=1 and one RATE=3 instance.
module tb_stream_pacer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       f1, v1, r1, e1;
    logic [7:0] d1, q1;
    logic [2:0] l1;
    logic       f3, v3, r3, e3;
    logic [7:0] d3, q3;
    logic [2:0] l3;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] sb1[$];
    logic [7:0] sb3[$];

    stream_pacer #(.WIDTH(8), .DEPTH(4), .RATE(1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(f1), .s_valid_i(v1), .s_ready_o(r1),
        .s_data_i(d1), .enable_o(e1), .data_o(q1), .level_o(l1));

    stream_pacer #(.WIDTH(8), .DEPTH(4), .RATE(3)) u_dut3 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(f3), .s_valid_i(v3), .s_ready_o(r3),
        .s_data_i(d3), .enable_o(e3), .data_o(q3), .level_o(l3));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic mid;
        @(negedge clk);
    endtask

    task automatic chk1(input logic [7:0] got, input logic [7:0] want, input string name);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic sb1_pop;
        logic [7:0] exp;
        n_checks++;
        if (sb1.size() == 0) begin
            n_fail++;
            $display("FAIL sb1_unexpected: got %h, want no word", q1);
        end else begin
            exp = sb1.pop_front();
            if (q1 !== exp) begin
                n_fail++;
                $display("FAIL sb1_data: got %h, want %h", q1, exp);
            end
        end
    endtask

    task automatic sb3_pop;
        logic [7:0] exp;
        n_checks++;
        if (sb3.size() == 0) begin
            n_fail++;
            $display("FAIL sb3_unexpected: got %h, want no word", q3);
        end else begin
            exp = sb3.pop_front();
            if (q3 !== exp) begin
                n_fail++;
                $display("FAIL sb3_data: got %h, want %h", q3, exp);
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        f1 = 0; v1 = 0; d1 = 0; f3 = 0; v3 = 0; d3 = 0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        mid();
        chk1({7'd0, e1}, 8'd0, "reset_en1");
        chk1(q1, 8'h00, "reset_data1");
        chk1({5'd0, l1}, 8'd0, "reset_level1");
        chk1({7'd0, r1}, 8'd1, "reset_ready1");
        chk1({7'd0, e3}, 8'd0, "reset_en3");
        chk1(q3, 8'h00, "reset_data3");
        chk1({5'd0, l3}, 8'd0, "reset_level3");
        chk1({7'd0, r3}, 8'd1, "reset_ready3");
    endtask

    task automatic test_latency;
        tick();
        v1 = 1'b1; d1 = 8'hA5;
        mid();
        chk1({7'd0, r1}, 8'd1, "lat_ready");
        if (r1 && v1) sb1.push_back(d1);
        tick();
        v1 = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            mid();
            chk1({7'd0, e1}, {7'd0, (c == 2)}, "lat_enable");
            if (e1) sb1_pop();
            if (c == 2) chk1({5'd0, l1}, 8'd0, "lat_level");
            tick();
        end
        chk1(8'(sb1.size()), 8'd0, "lat_sb_empty");
    endtask

    task automatic test_full_pacing;
        int idx = 0;
        int last = -1;
        int pulses = 0;
        logic saw_full = 1'b0;
        logic acc;
        for (int c = 0; c < 60; c++) begin
            v3 = (idx < 6);
            d3 = 8'(idx + 1);
            mid();
            acc = v3 && r3;
            if (l3 == 3'd4) begin
                saw_full = 1'b1;
                chk1({7'd0, r3}, 8'd0, "full_ready_low");
            end
            if (acc) sb3.push_back(d3);
            if (e3) begin
                sb3_pop();
                if (last >= 0) chk1(8'(c - last), 8'd3, "pace_gap");
                last = c;
                pulses++;
            end
            tick();
            if (acc) idx++;
        end
        v3 = 1'b0;
        chk1({7'd0, saw_full}, 8'd1, "full_reached");
        chk1(8'(pulses), 8'd6, "full_pulses");
        chk1(8'(sb3.size()), 8'd0, "full_sb_empty");
    endtask

    task automatic test_streaming;
        for (int c = 0; c < 22; c++) begin
            v1 = (c < 16);
            d1 = 8'(c);
            mid();
            if (v1) begin
                chk1({7'd0, r1}, 8'd1, "stream_ready");
                if (r1) sb1.push_back(d1);
            end
            chk1({7'd0, e1}, {7'd0, (c >= 2 && c <= 17)}, "stream_enable");
            if (e1) sb1_pop();
            n_checks++;
            if (l1 > 3'd2) begin
                n_fail++;
                $display("FAIL stream_level: got %0d, want <= 2", l1);
            end
            tick();
        end
        v1 = 1'b0;
        chk1(8'(sb1.size()), 8'd0, "stream_sb_empty");
    endtask

    task automatic test_flush;
        mid();
        chk1({5'd0, l3}, 8'd0, "flush_pre_level");
        tick();
        for (int c = 0; c < 4; c++) begin
            v3 = 1'b1;
            d3 = 8'(16 + c);
            mid();
            if (v3 && r3) sb3.push_back(d3);
            chk1({7'd0, e3}, {7'd0, (c == 2)}, "flush_pre_enable");
            if (e3) sb3_pop();
            tick();
        end
        v3 = 1'b0;
        f3 = 1'b1;
        mid();
        chk1({5'd0, l3}, 8'd3, "flush_at_level3");
        chk1({7'd0, r3}, 8'd0, "flush_ready_low");
        chk1({7'd0, e3}, 8'd0, "flush_cycle_enable");
        sb3.delete();
        tick();
        f3 = 1'b0;
        for (int c = 0; c < 8; c++) begin
            mid();
            if (c == 0) chk1({5'd0, l3}, 8'd0, "flush_level_zero");
            chk1({7'd0, e3}, 8'd0, "flush_no_enable");
            tick();
        end
        v3 = 1'b1;
        d3 = 8'h3C;
        mid();
        if (v3 && r3) sb3.push_back(d3);
        tick();
        v3 = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            mid();
            chk1({7'd0, e3}, {7'd0, (c == 2)}, "flush_post_enable");
            if (e3) sb3_pop();
            tick();
        end
        chk1(8'(sb3.size()), 8'd0, "flush_sb_empty");
    endtask

    task automatic test_async_reset;
        int idx = 0;
        logic acc;
        for (int c = 0; c < 8; c++) begin
            v3 = (idx < 6);
            d3 = 8'(80 + idx);
            v1 = 1'b1;
            d1 = 8'(96 + c);
            mid();
            acc = v3 && r3;
            if (acc) sb3.push_back(d3);
            if (v1 && r1) sb1.push_back(d1);
            if (e3) sb3_pop();
            if (e1) sb1_pop();
            tick();
            if (acc) idx++;
        end
        v3 = 1'b0;
        v1 = 1'b0;
        #2;
        n_checks++;
        if (l3 == 3'd0 || q3 == 8'h00) begin
            n_fail++;
            $display("FAIL areset_precond: got level %0d data %h, want both nonzero", l3, q3);
        end
        rst_n = 1'b0;
        #1;
        chk1({7'd0, e3}, 8'd0, "areset_en3");
        chk1(q3, 8'h00, "areset_data3");
        chk1({5'd0, l3}, 8'd0, "areset_level3");
        chk1({7'd0, e1}, 8'd0, "areset_en1");
        chk1(q1, 8'h00, "areset_data1");
        chk1({5'd0, l1}, 8'd0, "areset_level1");
        sb3.delete();
        sb1.delete();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
        for (int c = 0; c < 15; c++) begin
            mid();
            chk1({7'd0, e3}, 8'd0, "areset_no_stale3");
            chk1({7'd0, e1}, 8'd0, "areset_no_stale1");
            tick();
        end
        v3 = 1'b1;
        d3 = 8'h77;
        mid();
        if (v3 && r3) sb3.push_back(d3);
        tick();
        v3 = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            mid();
            chk1({7'd0, e3}, {7'd0, (c == 2)}, "areset_post_enable");
            if (e3) sb3_pop();
            tick();
        end
        chk1(8'(sb3.size()), 8'd0, "areset_sb_empty");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_latency();
        test_full_pacing();
        test_streaming();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/stream_pacer.md
STREAM_PACER -- requirements
Module: stream_pacer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 4: buffer depth in words, power of two, at least 2.
REQ-003 SHALL have parameter RATE, default 1: minimum cycle spacing between output words, at least 1.
REQ-004 SHALL have port clk_i  input  1: single clock, all logic rising-edge.
REQ-005 SHALL have port rst_ni  input  1: asynchronous active-low reset.
REQ-006 SHALL have port flush_i  input  1: synchronous buffer clear.
REQ-007 SHALL have port s_valid_i  input  1: upstream word valid.
REQ-008 SHALL have port s_ready_o  output  1: block can accept a word.
REQ-009 SHALL have port s_data_i  input  WIDTH: upstream word.
REQ-010 SHALL have port enable_o  output  1: one-cycle strobe qualifying data_o, drives the downstream stage's enable_i.
REQ-011 SHALL have port data_o  output  WIDTH: paced word, drives the downstream stage's data_i.
REQ-012 SHALL have port level_o  output  $clog2(DEPTH)+1: current buffer occupancy.

Function
REQ-013 SHALL accept a word on every rising edge where s_valid_i and s_ready_o are both high.
REQ-014 SHALL drive s_ready_o high exactly when level_o < DEPTH and flush_i is low, with no bypass: a full buffer refuses pushes even in a pop cycle.
REQ-015 SHALL store words in a circular buffer, with read and write pointers wrapping modulo DEPTH.
REQ-016 SHALL keep a pacing counter of width $clog2(RATE)+1 that reloads to RATE-1 on each pop, decrements by 1 per cycle, and holds at 0.
REQ-017 SHALL pop the head word in any cycle where the pacing counter is 0 and level_o > 0.
REQ-018 SHALL register pop outputs: enable_o high and data_o = popped word in the cycle after the pop.
REQ-019 SHALL give latency from the accept cycle N to enable_o high of cycle N+2 when the buffer is empty and the pacing counter is 0.
REQ-020 SHALL place consecutive enable_o pulses at least RATE cycles apart; RATE=1 permits a pulse every cycle.
REQ-021 SHALL hold data_o at its last popped value while enable_o is low.
REQ-022 SHALL update level_o as +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop.
REQ-023 SHALL preserve word order, with no loss or duplication.
REQ-024 SHALL, when flush_i is high, set on the next edge level_o=0, both pointers=0, pacing counter=0 and enable_o=0, with priority over push and pop; data_o holds.
REQ-025 SHALL never drive enable_o high when level_o was 0 in the preceding cycle.

Reset
REQ-026 SHALL, while rst_ni is low, immediately and without a clock force enable_o=0, data_o=0, level_o=0, both pointers=0 and pacing counter=0.
REQ-027 SHALL drive s_ready_o high after reset deassertion, with no other output asserted until the first accept.
REQ-028 SHALL leave buffer storage contents unreset.
REQ-029 SHALL discard all in-flight words when reset asserts mid-stream, and emit no stale word afterwards.

Structure
REQ-030 SHALL need no shared package; the pointer and counter widths are local parameters derived from DEPTH and RATE.
REQ-031 SHALL place the circular buffer in one sub-module, stream_pacer_fifo (push/pop/level/flush), with the pacing counter and output register in stream_pacer.

Verification
REQ-032 SHALL cover reset: hold rst_ni low 3 cycles, release -> enable_o=0, data_o=0x00, level_o=0, s_ready_o=1.
REQ-033 SHALL cover latency (WIDTH=8, RATE=1): accept 0xA5 in cycle 0 -> enable_o=1 in cycle 2 only, data_o=0xA5, level_o back to 0 by cycle 2.
REQ-034 SHALL cover full/pacing (DEPTH=4, RATE=3): offer 0x01..0x06 back-to-back -> s_ready_o=0 at level_o=4, enable_o pulses exactly 3 cycles apart, data_o order 0x01..0x06, none lost.
REQ-035 SHALL cover streaming (RATE=1): valid every cycle with 0x00..0x0F -> enable_o high 16 consecutive cycles from the third cycle, level_o never exceeds 2, s_ready_o stays 1.
REQ-036 SHALL cover flush: at level_o=3 pulse flush_i one cycle -> level_o=0 next cycle, no enable_o pulse afterwards, next accepted word 0x3C appears 2 cycles after its accept.
REQ-037 SHALL cover asynchronous reset: assert rst_ni low mid-stream between clock edges -> enable_o, data_o and level_o go 0 immediately; after release no pre-reset word appears.
